dmem_bus_bridge: RTL and testbench

- Sits between the single-cycle core's load/store path and the system data bus.
- Replaces the zero-latency data memory with a valid/ready bus that can insert wait states.
- Generates byte strobes and lane-replicated write data, and sign/zero-extends returned load data.
- Stalls the core (PC and register-file write hold) until each access completes; a watchdog bounds bus waits.

---
 rtl/dmem_bus_if.sv | 20 ++
 rtl/dmem_bus_bridge.sv | 196 +++++++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_if.sv
// Data-bus bundle between the load/store bridge (master) and the system data bus (slave).
interface dmem_bus_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's zero-latency load/store port onto a valid/ready data bus with a wait watchdog.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse core_misalign.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_re,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_funct3,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_err,
  output logic        core_misalign,
  dmem_bus_if.master  bus
);

  // Counter holds completed no-ready cycles; abort fires on the cycle that would make it TIMEOUT.
  localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r, state_nx;
  logic              stall_s, start_s, trap_s, hit_s, abort_s, misalign_s;
  logic              valid_r, we_r, err_r, mis_r;
  logic [31:0]       addr_r, wdata_r, rdata_r;
  logic [3:0]        strb_r;
  logic [1:0]        lo_r;
  logic [2:0]        f3_r;
  logic [CNT_W-1:0]  cnt_r;

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b000:  store_strb = 4'b0001 << lo;
      3'b001:  store_strb = 4'b0011 << {lo[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  store_data = {4{d[7:0]}};
      3'b001:  store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_format = {{24{b[7]}}, b};
      3'b001:  load_format = {{16{h[15]}}, h};
      3'b100:  load_format = {24'h00_0000, b};
      3'b101:  load_format = {16'h0000, h};
      default: load_format = w;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  // Halfword needs an even address, word needs a word-aligned address.
  always_comb begin
    misalign_s = 1'b0;
    if (core_funct3[1:0] == 2'b01) begin
      misalign_s = core_addr[0];
    end else if (core_funct3 == 3'b010) begin
      misalign_s = |core_addr[1:0];
    end else begin
      misalign_s = 1'b0;
    end
  end
`else
  assign misalign_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state, stall and per-cycle transfer events.
  always_comb begin
    state_nx = state_r;
    stall_s  = 1'b0;
    start_s  = 1'b0;
    trap_s   = 1'b0;
    hit_s    = 1'b0;
    abort_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s = core_re | core_we;
        if (core_re | core_we) begin
          start_s = 1'b1;
          if (misalign_s) begin
            trap_s   = 1'b1;
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_BUS;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BUS: begin
        stall_s = 1'b1;
        if (bus.bus_ready) begin
          hit_s    = 1'b1;
          state_nx = ST_DONE;
        end else if ((TIMEOUT != 32'd0) && (cnt_r == CNT_LAST)) begin
          abort_s  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_BUS;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture, watchdog count, read-word capture and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      strb_r  <= 4'b0000;
      wdata_r <= 32'h0000_0000;
      lo_r    <= 2'b00;
      f3_r    <= 3'b000;
      rdata_r <= 32'h0000_0000;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      mis_r   <= 1'b0;
    end else begin
      valid_r <= (state_nx == ST_BUS);
      err_r   <= abort_s;
      mis_r   <= trap_s;
      if (start_s) begin
        addr_r  <= {core_addr[31:2], 2'b00};
        we_r    <= core_we;
        strb_r  <= core_we ? store_strb(core_funct3, core_addr[1:0]) : 4'b0000;
        wdata_r <= store_data(core_funct3, core_wdata);
        lo_r    <= core_addr[1:0];
        f3_r    <= core_funct3;
        cnt_r   <= '0;
      end else if ((state_r == ST_BUS) && !bus.bus_ready) begin
        cnt_r <= cnt_r + 1'b1;
      end
      if (hit_s && !we_r) begin
        rdata_r <= bus.bus_rdata;
      end
    end
  end

  // Load result is only presented in DONE, and only for loads.
  always_comb begin
    core_rdata = 32'h0000_0000;
    if ((state_r == ST_DONE) && !we_r) begin
      if (err_r) begin
        core_rdata = ERR_RDATA;
      end else if (mis_r) begin
        core_rdata = 32'h0000_0000;
      end else begin
        core_rdata = load_format(rdata_r, lo_r, f3_r);
      end
    end else begin
      core_rdata = 32'h0000_0000;
    end
  end

  assign core_stall    = stall_s;
  assign core_err      = err_r;
  assign core_misalign = mis_r;
  assign bus.bus_valid = valid_r;
  assign bus.bus_we    = we_r;
  assign bus.bus_addr  = addr_r;
  assign bus.bus_wstrb = strb_r;
  assign bus.bus_wdata = wdata_r;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: a byte-lane model predicts every cycle, a negedge process compares.
module tb_dmem_bus_bridge;

  localparam int unsigned TO   = 6;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_re = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
  logic [2:0]  core_funct3 = 3'b000;
  logic [31:0] core_rdata;
  logic        core_stall, core_err, core_misalign;

  dmem_bus_if bus_if();

  dmem_bus_bridge #(.TIMEOUT(TO), .ERR_RDATA(ERRV)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_re(core_re), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .core_err(core_err), .core_misalign(core_misalign),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected outputs for the current cycle, written by the stimulus tasks.
  bit          chk_en = 1'b0, x_first = 1'b0, x_done = 1'b0;
  bit          x_stall, x_valid, x_err, x_mis, x_we;
  logic [31:0] x_rdata, x_addr, x_wdata;
  logic [3:0]  x_strb;
  int          stall_cnt = 0, valid_cnt = 0;
  logic [31:0] done_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int st_size(input logic [2:0] f3);
    if (f3 == 3'b000) return 1;
    if (f3 == 3'b001) return 2;
    return 4;
  endfunction

  function automatic int ld_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz, base;
    logic [3:0] s;
    sz = st_size(f3);
    base = (int'(a % 32'd4) / sz) * sz;
    for (int k = 0; k < 4; k++) s[k] = (k >= base) && (k < base + sz);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    logic [31:0] r;
    sz = st_size(f3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    int sz, base;
    logic [31:0] v, mask, one;
    sz = ld_size(f3);
    if (sz == 4) return w;
    base = (int'(a % 32'd4) / sz) * sz;
    one = 32'd1;
    mask = (one << (8 * sz)) - 32'd1;
    v = (w >> (8 * base)) & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01) return a[0];
    if (f3 == 3'b010) return a[1:0] != 2'b00;
    return 1'b0;
`else
    return (f3 == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Single compare process: every enabled cycle, DUT outputs against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(core_stall), 32'(x_stall));
      check("bus_valid", 32'(bus_if.bus_valid), 32'(x_valid));
      check("core_err", 32'(core_err), 32'(x_err));
      check("core_misalign", 32'(core_misalign), 32'(x_mis));
      check("core_rdata", core_rdata, x_rdata);
      if (x_valid) begin
        check("bus_addr", bus_if.bus_addr, x_addr);
        check("bus_we", 32'(bus_if.bus_we), 32'(x_we));
        check("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(x_strb));
        if (x_we) check("bus_wdata", bus_if.bus_wdata, x_wdata);
      end
      stall_cnt <= (x_first ? 0 : stall_cnt) + (core_stall ? 1 : 0);
      valid_cnt <= (x_first ? 0 : valid_cnt) + (bus_if.bus_valid ? 1 : 0);
      if (x_done) done_rdata <= core_rdata;
    end
  end

  // One access; waits<0 means bus_ready never comes. Returns just after the DONE compare.
  task automatic access(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input int waits, input logic [31:0] word);
    bit trap, abort;
    trap  = m_trap(f3, a);
    abort = 1'b0;
    @(posedge clk); #1;
    core_re = re; core_we = we; core_addr = a; core_wdata = d; core_funct3 = f3;
    bus_if.bus_rdata = word; bus_if.bus_ready = 1'b0;
    chk_en = 1'b1; x_first = 1'b1; x_done = 1'b0;
    x_stall = 1'b1; x_valid = 1'b0; x_err = 1'b0; x_mis = 1'b0; x_rdata = 32'h0;
    x_we = we; x_addr = {a[31:2], 2'b00};
    x_strb = we ? m_strb(f3, a) : 4'b0000;
    x_wdata = m_wdata(f3, d);
    if (!trap) begin
      for (int i = 1; i <= int'(TO); i++) begin
        @(posedge clk); #1;
        x_first = 1'b0; x_valid = 1'b1; x_stall = 1'b1;
        bus_if.bus_ready = (waits >= 0) && (i == waits + 1);
        if (bus_if.bus_ready) break;
        if (i == int'(TO)) abort = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b0;
    x_first = 1'b0; x_valid = 1'b0; x_stall = 1'b0; x_done = 1'b1;
    x_err = abort; x_mis = trap;
    x_rdata = (we || trap) ? 32'h0 : (abort ? ERRV : m_load(word, a, f3));
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      core_re = 1'b0; core_we = 1'b0;
      chk_en = 1'b1; x_first = 1'b1; x_done = 1'b0;
      x_stall = 1'b0; x_valid = 1'b0; x_err = 1'b0; x_mis = 1'b0; x_rdata = 32'h0;
    end
  endtask

  initial begin
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Model pinned against hand-computed values.
    check("model_lb", m_load(32'h1280FF00, 32'h102, 3'b000), 32'hFFFFFF80);
    check("model_lbu", m_load(32'h1280FF00, 32'h102, 3'b100), 32'h00000080);
    check("model_lh", m_load(32'h1280FF00, 32'h102, 3'b001), 32'h00001280);
    check("model_sb_strb", 32'(m_strb(3'b000, 32'h103)), 32'h8);
    check("model_sb_data", m_wdata(3'b000, 32'h000000EE), 32'hEEEEEEEE);

    #3;
    check("rst_valid", 32'(bus_if.bus_valid), 32'd0);
    check("rst_we", 32'(bus_if.bus_we), 32'd0);
    check("rst_addr", bus_if.bus_addr, 32'h0);
    check("rst_strb", 32'(bus_if.bus_wstrb), 32'h0);
    check("rst_wdata", bus_if.bus_wdata, 32'h0);
    check("rst_err", 32'(core_err), 32'd0);
    check("rst_misalign", 32'(core_misalign), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_rdata", core_rdata, 32'h0);
    #9 rst_n = 1'b1;

    idle(2);
    access(1'b0, 1'b1, 32'h100, 32'hA1B2C3D4, 3'b010, 0, 32'h0);
    check("sw_stall_cycles", 32'(stall_cnt), 32'd2);
    check("sw_valid_cycles", 32'(valid_cnt), 32'd1);
    access(1'b0, 1'b1, 32'h103, 32'h000000EE, 3'b000, 1, 32'h0);
    access(1'b1, 1'b0, 32'h102, 32'h0, 3'b000, 0, 32'h1280FF00);
    check("lb_result", done_rdata, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h102, 32'h0, 3'b100, 0, 32'h1280FF00);
    check("lbu_result", done_rdata, 32'h00000080);
    access(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 0, 32'h1280FF00);
    check("lh_result", done_rdata, 32'h00001280);
    access(1'b1, 1'b0, 32'h100, 32'h0, 3'b101, 2, 32'h8001F234);
    access(1'b1, 1'b0, 32'h100, 32'h0, 3'b001, 0, 32'h8001F234);
    check("lh_low_result", done_rdata, 32'hFFFFF234);
    access(1'b1, 1'b0, 32'h101, 32'h0, 3'b000, 0, 32'h8001F234);
    access(1'b0, 1'b1, 32'h102, 32'h1234ABCD, 3'b001, 0, 32'h0);
    access(1'b1, 1'b1, 32'h040, 32'h55667788, 3'b001, 0, 32'hFFFFFFFF);
    access(1'b0, 1'b1, 32'h001, 32'h0BADF00D, 3'b100, 0, 32'h0);
    idle(1);

    access(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 5, 32'hCAFEF00D);
    check("lw_wait_stall_cycles", 32'(stall_cnt), 32'd7);
    check("lw_wait_valid_cycles", 32'(valid_cnt), 32'd6);
    check("lw_wait_result", done_rdata, 32'hCAFEF00D);

    access(1'b1, 1'b0, 32'h108, 32'h0, 3'b010, -1, 32'h12345678);
    check("timeout_valid_cycles", 32'(valid_cnt), 32'(TO));
    check("timeout_result", done_rdata, ERRV);
    access(1'b0, 1'b1, 32'h10C, 32'h87654321, 3'b010, -1, 32'h0);
    idle(2);

    // Reset while the bus request is outstanding.
    @(posedge clk); #1;
    chk_en = 1'b0;
    core_re = 1'b1; core_we = 1'b0; core_addr = 32'h200; core_funct3 = 3'b010;
    bus_if.bus_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(bus_if.bus_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus_if.bus_valid), 32'd0);
    check("mid_rst_addr", bus_if.bus_addr, 32'h0);
    check("mid_rst_err", 32'(core_err), 32'd0);
    core_re = 1'b0;
    #1;
    check("mid_rst_stall", 32'(core_stall), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(1);
    access(1'b1, 1'b0, 32'h204, 32'h0, 3'b010, 0, 32'h0F1E2D3C);
    check("post_rst_lw", done_rdata, 32'h0F1E2D3C);

    access(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 0, 32'h11223344);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misalign_valid_cycles", 32'(valid_cnt), 32'd0);
    check("misalign_result", done_rdata, 32'h0);
`else
    check("misalign_ignored_result", done_rdata, 32'h11223344);
`endif
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
